// File: rtl/rx_pkt_framer_if.sv
// rtl/rx_pkt_framer_if.sv - bit stream in / packet out bundle for the receive framer
interface rx_pkt_framer_if #(
    parameter int PKT_BITS = 64
) ();
    logic                din;
    logic                bit_en;
    logic [PKT_BITS-1:0] dout;
    logic                pkt_rec;
    logic                pkt_err;
    logic                sync_det;
    logic                busy;
    logic [7:0]          pkt_cnt;

    // master: bit source / packet consumer side; slave: the framer itself
    modport master (
        output din, bit_en,
        input  dout, pkt_rec, pkt_err, sync_det, busy, pkt_cnt
    );
    modport slave (
        input  din, bit_en,
        output dout, pkt_rec, pkt_err, sync_det, busy, pkt_cnt
    );
endinterface

// File: rtl/rx_pkt_framer.sv
// rtl/rx_pkt_framer.sv - sync-word hunt, fixed-length packet assembly and CRC-8 check
module rx_pkt_framer #(
    parameter logic [15:0] SYNC_WORD = 16'hD391,
    parameter int          PKT_BITS  = 64,
    parameter int          TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    rx_pkt_framer_if.slave  bus
);
    localparam int CW = $clog2(PKT_BITS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(PKT_BITS - 1);
    localparam logic [CW-1:0] CRC_BITS = CW'(PKT_BITS - 8);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {HUNT, RECV, CHECK} state_t;

    state_t              state;
    logic [15:0]         sync_reg;
    logic [15:0]         sync_next;
    logic [PKT_BITS-1:0] shift_reg;
    logic [PKT_BITS-1:0] dout_r;
    logic [7:0]          crc;
    logic [7:0]          crc_next;
    logic [7:0]          pkt_cnt_r;
    logic [CW-1:0]       bit_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic                pkt_rec_r;
    logic                pkt_err_r;
    logic                sync_det_r;

    assign sync_next = {sync_reg[14:0], bus.din};
    assign crc_next  = {crc[6:0], 1'b0} ^ ((crc[7] ^ bus.din) ? 8'h07 : 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            sync_reg   <= '0;
            shift_reg  <= '0;
            dout_r     <= '0;
            crc        <= '0;
            pkt_cnt_r  <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            pkt_rec_r  <= 1'b0;
            pkt_err_r  <= 1'b0;
            sync_det_r <= 1'b0;
        end else begin
            pkt_rec_r  <= 1'b0;
            pkt_err_r  <= 1'b0;
            sync_det_r <= 1'b0;
            case (state)
                HUNT: begin
                    if (bus.bit_en) begin
                        sync_reg <= sync_next;
                        if (sync_next == SYNC_WORD) begin
                            sync_det_r <= 1'b1;
                            state      <= RECV;
                            bit_cnt    <= '0;
                            crc        <= '0;
                            tmo_cnt    <= '0;
                        end
                    end
                end
                RECV: begin
                    if (bus.bit_en) begin
                        shift_reg <= {shift_reg[PKT_BITS-2:0], bus.din};
                        bit_cnt   <= bit_cnt + 1'b1;
                        tmo_cnt   <= '0;
                        // trailing byte is the received CRC, so it stays out of the running CRC
                        if (bit_cnt < CRC_BITS)
                            crc <= crc_next;
                        if (bit_cnt == LAST_BIT)
                            state <= CHECK;
                    end else if (tmo_cnt == TMO_MAX - 1'b1) begin
                        tmo_cnt  <= TMO_MAX;
                        state    <= HUNT;
                        sync_reg <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (shift_reg[7:0] == crc) begin
                        dout_r    <= shift_reg;
                        pkt_rec_r <= 1'b1;
                        pkt_cnt_r <= pkt_cnt_r + 1'b1;
                    end else begin
                        pkt_err_r <= 1'b1;
                    end
                    state    <= HUNT;
                    sync_reg <= '0;
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign bus.dout     = dout_r;
    assign bus.pkt_rec  = pkt_rec_r;
    assign bus.pkt_err  = pkt_err_r;
    assign bus.sync_det = sync_det_r;
    assign bus.pkt_cnt  = pkt_cnt_r;
    assign bus.busy     = (state != HUNT);
endmodule

// File: tb/tb_rx_pkt_framer.sv
// tb/tb_rx_pkt_framer.sv - directed bench for rx_pkt_framer
module tb_rx_pkt_framer;
    localparam logic [63:0] SYNC  = 64'h0000_0000_0000_D391;
    localparam logic [63:0] PKT_A = 64'h0000_0000_0000_0107;
    localparam logic [63:0] PKT_B = 64'h0000_0000_0000_020E;
    localparam logic [63:0] PKT_X = 64'h0000_0000_0000_0108;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   sync_cnt = 0;
    int   rec_cnt = 0;
    int   err_cnt = 0;
    int   s0, r0, e0;

    rx_pkt_framer_if #(.PKT_BITS(64)) bus ();

    rx_pkt_framer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sync_det) sync_cnt++;
        if (bus.pkt_rec)  rec_cnt++;
        if (bus.pkt_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        bus.din    = b;
        bus.bit_en = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            strobe(v[i]);
            if (i != 0) idle(gap);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.din    = 1'b0;
        bus.bit_en = 1'b0;
        idle(3);
        check("reset_dout", bus.dout, 64'h0);
        check("reset_cnt", {56'h0, bus.pkt_cnt}, 64'h0);
        check("reset_flags", {60'h0, bus.busy, bus.pkt_rec, bus.pkt_err, bus.sync_det}, 64'h0);
        rst_n = 1'b1;
        idle(2);

        // good packet, one strobe every 4 clocks
        send_bits(SYNC, 16, 3);
        check("t1_sync_det", {63'h0, bus.sync_det}, 64'h1);
        check("t1_busy", {63'h0, bus.busy}, 64'h1);
        idle(3);
        send_bits(PKT_A, 64, 3);
        check("t1_rec_early", {63'h0, bus.pkt_rec}, 64'h0);
        idle(1);
        check("t1_rec", {63'h0, bus.pkt_rec}, 64'h1);
        check("t1_dout", bus.dout, PKT_A);
        check("t1_cnt", {56'h0, bus.pkt_cnt}, 64'h1);
        check("t1_idle", {63'h0, bus.busy}, 64'h0);
        idle(1);
        check("t1_rec_pulse", {63'h0, bus.pkt_rec}, 64'h0);
        check("t1_sync_cnt", sync_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        // bad CRC
        send_bits(SYNC, 16, 3);
        idle(3);
        send_bits(PKT_X, 64, 3);
        idle(1);
        check("t2_err", {62'h0, bus.pkt_err, bus.pkt_rec}, 64'h2);
        check("t2_dout", bus.dout, PKT_A);
        check("t2_cnt", {56'h0, bus.pkt_cnt}, 64'h1);
        idle(1);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_rec_cnt", rec_cnt, 1);

        // near-miss prefix and filler, then the real sync and a zero packet
        s0 = sync_cnt;
        send_bits(64'hD390, 16, 3);
        idle(3);
        send_bits(64'h4A6, 12, 3);
        idle(3);
        check("t3_no_false_sync", sync_cnt, s0);
        send_bits(SYNC, 16, 3);
        idle(3);
        send_bits(64'h0, 64, 3);
        idle(2);
        check("t3_sync_cnt", sync_cnt, s0 + 1);
        check("t3_rec_cnt", rec_cnt, 2);
        check("t3_dout", bus.dout, 64'h0);
        check("t3_cnt", {56'h0, bus.pkt_cnt}, 64'h2);

        // timeout after 20 packet bits
        r0 = rec_cnt;
        e0 = err_cnt;
        send_bits(SYNC, 16, 3);
        idle(3);
        send_bits(64'h0, 20, 3);
        idle(254);
        check("t4_busy_before", {63'h0, bus.busy}, 64'h1);
        idle(1);
        check("t4_busy_after", {63'h0, bus.busy}, 64'h0);
        check("t4_no_pulse", rec_cnt + err_cnt, r0 + e0);
        idle(45);
        send_bits(SYNC, 16, 3);
        idle(3);
        send_bits(PKT_A, 64, 3);
        idle(1);
        check("t4_rec", {63'h0, bus.pkt_rec}, 64'h1);
        check("t4_dout", bus.dout, PKT_A);
        check("t4_cnt", {56'h0, bus.pkt_cnt}, 64'h3);

        // reset after 30 packet bits, then the remaining 34 bits
        send_bits(SYNC, 16, 3);
        idle(3);
        send_bits(PKT_A >> 34, 30, 3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("t5_dout", bus.dout, 64'h0);
        check("t5_cnt", {56'h0, bus.pkt_cnt}, 64'h0);
        check("t5_flags", {60'h0, bus.busy, bus.pkt_rec, bus.pkt_err, bus.sync_det}, 64'h0);
        r0 = rec_cnt;
        idle(3);
        send_bits(PKT_A, 34, 3);
        idle(2);
        check("t5_no_rec", rec_cnt, r0);
        check("t5_busy", {63'h0, bus.busy}, 64'h0);

        // 256 back-to-back packets, a stray strobe in every CHECK cycle
        r0 = rec_cnt;
        s0 = sync_cnt;
        for (int i = 0; i < 256; i++) begin
            send_bits(SYNC, 16, 0);
            send_bits(i[0] ? PKT_B : PKT_A, 64, 0);
            strobe(1'b1);
        end
        idle(2);
        check("t6_rec_cnt", rec_cnt - r0, 256);
        check("t6_sync_cnt", sync_cnt - s0, 256);
        check("t6_cnt_wrap", {56'h0, bus.pkt_cnt}, 64'h0);
        check("t6_dout", bus.dout, PKT_B);

        // the CHECK-cycle strobe must not count as the first sync bit
        send_bits(SYNC, 16, 0);
        send_bits(PKT_A, 64, 0);
        strobe(1'b1);
        s0 = sync_cnt;
        send_bits(SYNC, 15, 0);
        idle(2);
        check("t6_check_ignored", sync_cnt, s0);
        check("t6_final_cnt", {56'h0, bus.pkt_cnt}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
